// File: rtl/pipe_regfile_if.sv
// Bundle for the register file: two combinational read ports, two write
// ports, and the busy-scoreboard issue port.
interface pipe_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              RdBusy1;
  logic              RdBusy2;
  logic              WE0;
  logic              WE1;
  logic [ADDR_W-1:0] WA0;
  logic [ADDR_W-1:0] WA1;
  logic [DATA_W-1:0] WD0;
  logic [DATA_W-1:0] WD1;
  logic              IssEn;
  logic [ADDR_W-1:0] IssReg;
  logic              IssReady;
  logic [ADDR_W:0]   BusyCnt;

  modport master (
    output ReadReg1, ReadReg2, WE0, WE1, WA0, WA1, WD0, WD1, IssEn, IssReg,
    input  ReadData1, ReadData2, RdBusy1, RdBusy2, IssReady, BusyCnt
  );

  modport slave (
    input  ReadReg1, ReadReg2, WE0, WE1, WA0, WA1, WD0, WD1, IssEn, IssReg,
    output ReadData1, ReadData2, RdBusy1, RdBusy2, IssReady, BusyCnt
  );
endinterface

// File: rtl/pipe_regfile.sv
// Dual-write register file with a per-register busy scoreboard for
// destination reservation; register 0 is hardwired to zero and never busy.
module pipe_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input logic           CLK,
  input logic           RST,
  pipe_regfile_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit BYP   = (BYPASS != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

  logic wr0_vld, wr1_vld;
  logic iss_ready, iss_acc;
  logic hit0_r1, hit1_r1, hit0_r2, hit1_r2;

  always_comb begin
    wr0_vld   = bus.WE0 && (bus.WA0 != '0);
    wr1_vld   = bus.WE1 && (bus.WA1 != '0);
    iss_ready = (bus.IssReg == '0) || !busy_q[bus.IssReg]
                || (wr0_vld && (bus.WA0 == bus.IssReg))
                || (wr1_vld && (bus.WA1 == bus.IssReg));
    iss_acc   = bus.IssEn && iss_ready && (bus.IssReg != '0);
  end

  // Writes clear busy bits first so a same-cycle accepted issue re-sets them.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr0_vld) begin
      mem_d[bus.WA0]  = bus.WD0;
      busy_d[bus.WA0] = 1'b0;
    end
    if (wr1_vld) begin
      mem_d[bus.WA1]  = bus.WD1;
      busy_d[bus.WA1] = 1'b0;
    end
    if (iss_acc) begin
      busy_d[bus.IssReg] = 1'b1;
    end
    busy_cnt_d = (ADDR_W + 1)'($countones(busy_d));
  end

  always_comb begin
    hit0_r1 = BYP && wr0_vld && (bus.WA0 == bus.ReadReg1);
    hit1_r1 = BYP && wr1_vld && (bus.WA1 == bus.ReadReg1);
    hit0_r2 = BYP && wr0_vld && (bus.WA0 == bus.ReadReg2);
    hit1_r2 = BYP && wr1_vld && (bus.WA1 == bus.ReadReg2);

    if (hit1_r1)      bus.ReadData1 = bus.WD1;
    else if (hit0_r1) bus.ReadData1 = bus.WD0;
    else              bus.ReadData1 = mem_q[bus.ReadReg1];

    if (hit1_r2)      bus.ReadData2 = bus.WD1;
    else if (hit0_r2) bus.ReadData2 = bus.WD0;
    else              bus.ReadData2 = mem_q[bus.ReadReg2];

    bus.RdBusy1  = busy_q[bus.ReadReg1] && !(hit0_r1 || hit1_r1);
    bus.RdBusy2  = busy_q[bus.ReadReg2] && !(hit0_r2 || hit1_r2);
    bus.IssReady = iss_ready;
    bus.BusyCnt  = busy_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile: each step drives inputs shortly after the
// rising edge and compares the live outputs directly at the falling edge.
module tb_pipe_regfile;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   pipe_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   pipe_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus)
   );

   int testsRun    = 0;
   int testsFailed = 0;

   // Records the outcome of one comparison and prints a message on mismatch.
   task automatic checkOutput(input bit ok, input string name,
                              input logic [31:0] got, input logic [31:0] expVal);
      testsRun++;
      if (!ok) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, expVal);
      end
   endtask

   // Drives every input of the register file to its idle value.
   task automatic applyStimulus();
      bus.ReadReg1 = '0;
      bus.ReadReg2 = '0;
      bus.WE0      = 1'b0;
      bus.WE1      = 1'b0;
      bus.WA0      = '0;
      bus.WA1      = '0;
      bus.WD0      = '0;
      bus.WD1      = '0;
      bus.IssEn    = 1'b0;
      bus.IssReg   = '0;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Guards against a hung simulation.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   // Main directed sequence; comparisons happen at the falling edge of each step.
   initial begin
      applyStimulus();
      rst_n = 1'b0;
      repeat (2) nextCycle();
      rst_n = 1'b1;

      bus.ReadReg1 = 5'd5;
      @(negedge clk);
      checkOutput(bus.ReadData1 === 32'h0, "rst_rd1", bus.ReadData1, 32'h0);
      checkOutput(bus.ReadData2 === 32'h0, "rst_rd2", bus.ReadData2, 32'h0);
      checkOutput(bus.RdBusy1 === 1'b0, "rst_busy1", {31'd0, bus.RdBusy1}, 32'h0);
      checkOutput(bus.RdBusy2 === 1'b0, "rst_busy2", {31'd0, bus.RdBusy2}, 32'h0);
      checkOutput(bus.IssReady === 1'b1, "rst_issready", {31'd0, bus.IssReady}, 32'h1);
      checkOutput(bus.BusyCnt === 6'd0, "rst_busycnt", {26'd0, bus.BusyCnt}, 32'h0);
      nextCycle();

      applyStimulus();
      bus.WE0 = 1'b1; bus.WA0 = 5'd5; bus.WD0 = 32'h12345678; bus.ReadReg1 = 5'd5;
      @(negedge clk);
      checkOutput(bus.ReadData1 === 32'h12345678, "bypass_wr0", bus.ReadData1, 32'h12345678);
      nextCycle();

      applyStimulus();
      bus.ReadReg1 = 5'd5;
      @(negedge clk);
      checkOutput(bus.ReadData1 === 32'h12345678, "stored_wr0", bus.ReadData1, 32'h12345678);
      checkOutput(bus.BusyCnt === 6'd0, "cnt_plain_write", {26'd0, bus.BusyCnt}, 32'h0);
      nextCycle();

      applyStimulus();
      bus.WE0 = 1'b1; bus.WA0 = 5'd7; bus.WD0 = 32'hAAAA0000;
      bus.WE1 = 1'b1; bus.WA1 = 5'd7; bus.WD1 = 32'h0000BBBB;
      bus.ReadReg2 = 5'd7;
      @(negedge clk);
      checkOutput(bus.ReadData2 === 32'h0000BBBB, "bypass_p1_wins", bus.ReadData2, 32'h0000BBBB);
      nextCycle();

      applyStimulus();
      bus.ReadReg2 = 5'd7;
      @(negedge clk);
      checkOutput(bus.ReadData2 === 32'h0000BBBB, "stored_p1_wins", bus.ReadData2, 32'h0000BBBB);
      nextCycle();

      applyStimulus();
      bus.IssEn = 1'b1; bus.IssReg = 5'd3;
      @(negedge clk);
      checkOutput(bus.IssReady === 1'b1, "iss3_first", {31'd0, bus.IssReady}, 32'h1);
      nextCycle();

      applyStimulus();
      bus.IssEn = 1'b1; bus.IssReg = 5'd3; bus.ReadReg2 = 5'd3;
      @(negedge clk);
      checkOutput(bus.BusyCnt === 6'd1, "cnt_after_iss3", {26'd0, bus.BusyCnt}, 32'h1);
      checkOutput(bus.RdBusy2 === 1'b1, "rdbusy2_reg3", {31'd0, bus.RdBusy2}, 32'h1);
      checkOutput(bus.IssReady === 1'b0, "iss3_blocked", {31'd0, bus.IssReady}, 32'h0);
      nextCycle();

      applyStimulus();
      bus.ReadReg2 = 5'd3;
      @(negedge clk);
      checkOutput(bus.BusyCnt === 6'd1, "cnt_blocked_iss", {26'd0, bus.BusyCnt}, 32'h1);
      checkOutput(bus.RdBusy2 === 1'b1, "rdbusy2_still", {31'd0, bus.RdBusy2}, 32'h1);
      nextCycle();

      applyStimulus();
      bus.WE0 = 1'b1; bus.WA0 = 5'd3; bus.WD0 = 32'h33; bus.ReadReg2 = 5'd3;
      @(negedge clk);
      checkOutput(bus.RdBusy2 === 1'b0, "rdbusy2_bypass_clear", {31'd0, bus.RdBusy2}, 32'h0);
      checkOutput(bus.ReadData2 === 32'h33, "rd2_bypass_reg3", bus.ReadData2, 32'h33);
      nextCycle();

      applyStimulus();
      bus.ReadReg2 = 5'd3;
      @(negedge clk);
      checkOutput(bus.BusyCnt === 6'd0, "cnt_after_wr3", {26'd0, bus.BusyCnt}, 32'h0);
      checkOutput(bus.RdBusy2 === 1'b0, "rdbusy2_cleared", {31'd0, bus.RdBusy2}, 32'h0);
      nextCycle();

      applyStimulus();
      bus.IssEn = 1'b1; bus.IssReg = 5'd4;
      @(negedge clk);
      checkOutput(bus.IssReady === 1'b1, "iss4_first", {31'd0, bus.IssReady}, 32'h1);
      nextCycle();

      applyStimulus();
      bus.IssEn = 1'b1; bus.IssReg = 5'd4;
      bus.WE1 = 1'b1; bus.WA1 = 5'd4; bus.WD1 = 32'h44; bus.ReadReg1 = 5'd4;
      @(negedge clk);
      checkOutput(bus.IssReady === 1'b1, "iss4_with_write", {31'd0, bus.IssReady}, 32'h1);
      checkOutput(bus.RdBusy1 === 1'b0, "rdbusy1_bypass4", {31'd0, bus.RdBusy1}, 32'h0);
      checkOutput(bus.BusyCnt === 6'd1, "cnt_before_setwins", {26'd0, bus.BusyCnt}, 32'h1);
      nextCycle();

      applyStimulus();
      bus.ReadReg1 = 5'd4;
      @(negedge clk);
      checkOutput(bus.BusyCnt === 6'd1, "cnt_set_wins", {26'd0, bus.BusyCnt}, 32'h1);
      checkOutput(bus.RdBusy1 === 1'b1, "busy4_set_wins", {31'd0, bus.RdBusy1}, 32'h1);
      checkOutput(bus.ReadData1 === 32'h44, "data4_written", bus.ReadData1, 32'h44);
      nextCycle();

      applyStimulus();
      bus.WE0 = 1'b1; bus.WA0 = 5'd4; bus.WD0 = 32'h45;
      nextCycle();

      applyStimulus();
      @(negedge clk);
      checkOutput(bus.BusyCnt === 6'd0, "cnt_after_wr4", {26'd0, bus.BusyCnt}, 32'h0);
      nextCycle();

      applyStimulus();
      bus.WE0 = 1'b1; bus.WA0 = 5'd0; bus.WD0 = 32'hFFFF;
      bus.WE1 = 1'b1; bus.WA1 = 5'd0; bus.WD1 = 32'hEEEE;
      bus.IssEn = 1'b1; bus.IssReg = 5'd0;
      @(negedge clk);
      checkOutput(bus.ReadData1 === 32'h0, "reg0_no_bypass", bus.ReadData1, 32'h0);
      checkOutput(bus.IssReady === 1'b1, "reg0_issready", {31'd0, bus.IssReady}, 32'h1);
      checkOutput(bus.RdBusy1 === 1'b0, "reg0_not_busy", {31'd0, bus.RdBusy1}, 32'h0);
      nextCycle();

      applyStimulus();
      @(negedge clk);
      checkOutput(bus.ReadData1 === 32'h0, "reg0_stored", bus.ReadData1, 32'h0);
      checkOutput(bus.BusyCnt === 6'd0, "reg0_cnt", {26'd0, bus.BusyCnt}, 32'h0);
      nextCycle();

      applyStimulus();
      bus.WE0 = 1'b1; bus.WA0 = 5'd10; bus.WD0 = 32'hA0A0A0A0;
      bus.WE1 = 1'b1; bus.WA1 = 5'd11; bus.WD1 = 32'hB1B1B1B1;
      bus.ReadReg1 = 5'd10; bus.ReadReg2 = 5'd11;
      @(negedge clk);
      checkOutput(bus.ReadData1 === 32'hA0A0A0A0, "bypass_port0_r1", bus.ReadData1, 32'hA0A0A0A0);
      checkOutput(bus.ReadData2 === 32'hB1B1B1B1, "bypass_port1_r2", bus.ReadData2, 32'hB1B1B1B1);
      nextCycle();

      for (int i = 1; i <= 4; i++) begin
         applyStimulus();
         bus.IssEn = 1'b1; bus.IssReg = 5'(i);
         @(negedge clk);
         checkOutput(bus.IssReady === 1'b1, "iss_fill", {31'd0, bus.IssReady}, 32'h1);
         nextCycle();
      end

      applyStimulus();
      bus.ReadReg1 = 5'd2;
      @(negedge clk);
      checkOutput(bus.BusyCnt === 6'd4, "cnt_four", {26'd0, bus.BusyCnt}, 32'h4);
      checkOutput(bus.RdBusy1 === 1'b1, "busy2_reserved", {31'd0, bus.RdBusy1}, 32'h1);
      nextCycle();

      applyStimulus();
      rst_n = 1'b0;
      bus.WE0 = 1'b1; bus.WA0 = 5'd5; bus.WD0 = 32'hDEAD;
      bus.IssEn = 1'b1; bus.IssReg = 5'd9;
      nextCycle();

      rst_n = 1'b1;
      applyStimulus();
      bus.ReadReg1 = 5'd5; bus.ReadReg2 = 5'd2; bus.IssReg = 5'd9;
      @(negedge clk);
      checkOutput(bus.BusyCnt === 6'd0, "midrst_cnt", {26'd0, bus.BusyCnt}, 32'h0);
      checkOutput(bus.ReadData1 === 32'h0, "midrst_rd1", bus.ReadData1, 32'h0);
      checkOutput(bus.RdBusy2 === 1'b0, "midrst_busy2", {31'd0, bus.RdBusy2}, 32'h0);
      checkOutput(bus.IssReady === 1'b1, "midrst_issready", {31'd0, bus.IssReady}, 32'h1);
      nextCycle();

      applyStimulus();
      bus.ReadReg1 = 5'd7; bus.ReadReg2 = 5'd10;
      @(negedge clk);
      checkOutput(bus.ReadData1 === 32'h0, "midrst_reg7", bus.ReadData1, 32'h0);
      checkOutput(bus.ReadData2 === 32'h0, "midrst_reg10", bus.ReadData2, 32'h0);
      nextCycle();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
